// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronise and filter the PS/2 lines, decode 11-bit frames,
// and present bytes on a valid/ready output. Optional parity enforcement via PS2_RX_PARITY_CHECK_EN.
module ps2_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [3:0]  FILT_MAX = 4'(FILTER_LEN - 1);
  localparam logic [15:0] TO_MAX   = 16'(TIMEOUT - 1);

  logic [1:0]  clkSync_q, datSync_q;
  logic        clkFilt_q, datFilt_q, clkFiltPrev_q;
  logic [3:0]  clkCnt_q, datCnt_q;
  state_t      state_q;
  logic [2:0]  bitCnt_q;
  logic [7:0]  shift_q;
  logic        parAcc_q;
  logic [15:0] timer_q;
  logic        fall;
  logic        timerHit;
  logic        parityOk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkSync_q <= 2'b11;
      datSync_q <= 2'b11;
    end else begin
      clkSync_q <= {clkSync_q[0], ps2_clk};
      datSync_q <= {datSync_q[0], ps2_dat};
    end
  end

  // A filtered line only follows its synchronised input after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkFilt_q     <= 1'b1;
      clkCnt_q      <= 4'd0;
      clkFiltPrev_q <= 1'b1;
    end else begin
      clkFiltPrev_q <= clkFilt_q;
      if (clkSync_q[1] == clkFilt_q) begin
        clkCnt_q <= 4'd0;
      end else if (clkCnt_q == FILT_MAX) begin
        clkFilt_q <= clkSync_q[1];
        clkCnt_q  <= 4'd0;
      end else begin
        clkCnt_q <= clkCnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      datFilt_q <= 1'b1;
      datCnt_q  <= 4'd0;
    end else begin
      if (datSync_q[1] == datFilt_q) begin
        datCnt_q <= 4'd0;
      end else if (datCnt_q == FILT_MAX) begin
        datFilt_q <= datSync_q[1];
        datCnt_q  <= 4'd0;
      end else begin
        datCnt_q <= datCnt_q + 4'd1;
      end
    end
  end

  assign fall     = clkFiltPrev_q & ~clkFilt_q;
  assign timerHit = (timer_q == TO_MAX);

  // The accumulator starts at 1, so a correctly odd-parity frame leaves it at 0.
`ifdef PS2_RX_PARITY_CHECK_EN
  assign parityOk = ~parAcc_q;
`else
  assign parityOk = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= 3'd0;
      shift_q   <= 8'h00;
      parAcc_q  <= 1'b0;
      timer_q   <= 16'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (state_q == IDLE || fall) begin
        timer_q <= 16'd0;
      end else begin
        timer_q <= timer_q + 16'd1;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (fall && !datFilt_q) begin
            state_q  <= DATA;
            bitCnt_q <= 3'd0;
            parAcc_q <= 1'b1;
          end
        end
        DATA: begin
          if (fall) begin
            shift_q  <= {datFilt_q, shift_q[7:1]};
            parAcc_q <= parAcc_q ^ datFilt_q;
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end else if (timerHit) begin
            state_q   <= IDLE;
            frame_err <= 1'b1;
          end
        end
        PARITY: begin
          if (fall) begin
            parAcc_q <= parAcc_q ^ datFilt_q;
            state_q  <= STOP;
          end else if (timerHit) begin
            state_q   <= IDLE;
            frame_err <= 1'b1;
          end
        end
        STOP: begin
          if (fall) begin
            state_q <= IDLE;
            if (datFilt_q && parityOk) begin
              // A byte arriving in the same cycle as a handshake replaces the consumed one.
              if (!out_valid || out_ready) begin
                out_data  <= shift_q;
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else if (timerHit) begin
            state_q   <= IDLE;
            frame_err <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning consecutive clk cycles a synchronised PS/2 line must be stable before its filtered value changes (range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 2000, meaning clk cycles without a PS/2 falling edge after which a partial frame is abandoned (range 16..65535).
REQ-003 SHALL have ports:
- clk  input  1  system clock; single clock domain, all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  PS/2 clock line, asynchronous, idles high.
- ps2_dat  input  1  PS/2 data line, asynchronous, idles high.
- out_data  output  8  received byte.
- out_valid  output  1  out_data holds an unconsumed byte.
- out_ready  input  1  consumer accepts out_data while out_valid is high.
- frame_err  output  1  one-cycle pulse: bad stop bit, parity failure or timeout.
- overrun  output  1  one-cycle pulse: completed byte dropped because the output register was full.

Function
REQ-004 SHALL pass ps2_clk and ps2_dat each through a 2-flop synchroniser, then a stability filter per FILTER_LEN; filtered values SHALL reset to 1.
REQ-005 SHALL generate an internal fall strobe for one cycle when filtered ps2_clk goes 1->0; data SHALL be sampled from filtered ps2_dat in that same cycle only.
REQ-006 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-007 IDLE: fall with dat=0 (start bit) -> DATA, bit counter=0, parity accumulator=1; fall with dat=1 -> ignored, stay IDLE.
REQ-008 DATA: each fall shifts dat in LSB first (first data bit lands in bit 0); after the 8th bit -> PARITY.
REQ-009 PARITY: fall captures parity bit -> STOP.
REQ-010 STOP: fall with dat=1 and parity valid -> byte complete, IDLE; fall with dat=0 -> frame_err pulse, byte discarded, IDLE.
REQ-011 Parity valid SHALL mean XOR of 8 data bits and parity bit equals 1 (odd parity).
REQ-012 A cycle counter SHALL reset on every fall and in IDLE; reaching TIMEOUT in DATA, PARITY or STOP -> frame_err pulse, partial byte discarded, IDLE.
REQ-013 On byte complete, the cycle after the stop-bit fall strobe SHALL show out_valid=1 and out_data=byte.
REQ-014 out_valid SHALL stay high and out_data stable until a cycle with out_valid&out_ready; out_valid SHALL fall the following cycle unless a new byte loads.
REQ-015 Byte completion in the same cycle as out_valid&out_ready SHALL load the new byte, out_valid staying 1, no overrun.
REQ-016 Byte completion while out_valid=1 and out_ready=0 SHALL drop the new byte, keep the old, and pulse overrun.
REQ-017 frame_err and overrun SHALL never be asserted for more than one consecutive cycle per event.

Reset
REQ-018 reset_n low SHALL asynchronously force: FSM=IDLE, counters=0, synchronisers and filters=1, out_data=0x00, out_valid=0, frame_err=0, overrun=0.
REQ-019 Reset released mid-frame SHALL resume in IDLE; remaining bits of the interrupted frame SHALL not produce a byte unless they form a new valid start/frame.

Configuration
REQ-020 Macro PS2_RX_PARITY_CHECK_EN defined: REQ-010 parity check enforced; parity failure -> frame_err pulse, byte discarded.
REQ-021 Macro PS2_RX_PARITY_CHECK_EN undefined: parity bit sampled but ignored; any frame with stop bit 1 completes; frame_err only for stop-bit or timeout.

Verification
REQ-022 Frame 0x00 (start 0, data 00000000, parity 1, stop 1), out_ready=1 -> out_valid pulse, out_data=0x00, no frame_err.
REQ-023 Bytes 0x00..0x0F back-to-back, correct odd parity, out_ready=1 -> 16 bytes out in order, no errors.
REQ-024 Frame 0x07 with parity bit 1 (wrong), macro defined -> frame_err pulse, out_valid stays 0; macro undefined -> out_data=0x07.
REQ-025 Frames 0x12 then 0x34, out_ready=0 -> out_data=0x12 held, overrun pulse at second completion; out_ready=1 -> out_valid falls next cycle.
REQ-026 Start bit plus 3 data bits, then ps2_clk held high > TIMEOUT cycles -> frame_err pulse, IDLE; following valid frame 0x5A -> out_data=0x5A.
REQ-027 1-cycle low glitch on ps2_clk with FILTER_LEN=4 -> no fall strobe, no state change; reset_n pulsed low mid-frame -> all outputs at REQ-018 values immediately.
